// File: rtl/handshake_rx_if.sv
// Bus bundle for handshake_rx: remote req/ack/data side plus local valid/ready stream.
// slave  : the receiver (handshake_rx) side.
// master : the environment side (remote writer plus local consumer).
interface handshake_rx_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             i_req;
    logic [WIDTH-1:0] i_data;
    logic             o_ack;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             i_ready;
    logic [CW-1:0]    o_count;

    modport slave (
        input  i_req,
        input  i_data,
        input  i_ready,
        output o_ack,
        output o_valid,
        output o_data,
        output o_count
    );

    modport master (
        output i_req,
        output i_data,
        output i_ready,
        input  o_ack,
        input  o_valid,
        input  o_data,
        input  o_count
    );
endinterface

// File: rtl/handshake_rx.sv
// handshake_rx: receiving end of a four-phase req/ack CDC handshake.
// Synchronises the remote request, captures the word into a DEPTH-entry FIFO
// and presents the FIFO head on a local valid/ready stream.
// Optional macro HANDSHAKE_RX_STATS_EN adds o_xfer_count and o_stall ports.
module handshake_rx #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    handshake_rx_if.slave  bus
`ifdef HANDSHAKE_RX_STATS_EN
    ,
    output logic [15:0]    o_xfer_count,
    output logic           o_stall
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 req_s;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 ack_q, ack_d;

    logic                 full;
    logic                 wr_en;
    logic                 rd_en;

    // Request synchroniser; only its last stage is used internally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Full is judged on the pre-pop occupancy, so a same-cycle pop never lets a write in.
    assign full  = (count_q == CW'(DEPTH));
    assign rd_en = valid_q & bus.i_ready;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_s && !full) state_d = ACK;
            ACK:  if (!req_s)         state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // FSM outputs: one write per request phase, ack mirrors the ACK state.
    always_comb begin
        wr_en = 1'b0;
        ack_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_en = req_s && !full;
                ack_d = req_s && !full;
            end
            ACK: begin
                ack_d = req_s;
            end
            default: begin
                wr_en = 1'b0;
                ack_d = 1'b0;
            end
        endcase
    end

    // FIFO pointer, occupancy and registered head computation.
    always_comb begin
        wr_ptr_d = wr_en ? AW'(wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = rd_en ? AW'(rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
        data_d  = '0;
        if (count_d != '0) begin
            // New word becomes head when it lands in the slot the read pointer moves to.
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                data_d = bus.i_data;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.i_data;
        end
    end

    // FIFO control and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ack_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
        end
    end

    assign bus.o_ack   = ack_q;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_count = count_q;

`ifdef HANDSHAKE_RX_STATS_EN
    logic [15:0] xfer_q;
    logic        stall_q;

    // Transfer counter (wrapping) and registered backpressure indicator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            xfer_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            if (wr_en) begin
                xfer_q <= 16'(xfer_q + 16'd1);
            end
            stall_q <= (state_q == IDLE) && req_s && full;
        end
    end

    assign o_xfer_count = xfer_q;
    assign o_stall      = stall_q;
`endif

endmodule

// File: tb/tb_handshake_rx.sv
// Directed self-checking bench for handshake_rx (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
module tb_handshake_rx;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    handshake_rx_if #(.WIDTH(8), .DEPTH(4)) bus ();

`ifdef HANDSHAKE_RX_STATS_EN
    logic [15:0] xfer_count;
    logic        stall;
`endif

    handshake_rx #(
        .WIDTH       (8),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus)
`ifdef HANDSHAKE_RX_STATS_EN
        ,
        .o_xfer_count (xfer_count),
        .o_stall      (stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for o_ack to reach v; a timeout shows up as a failed check.
    task automatic wait_ack(input logic v, input string tag);
        for (int i = 0; i < 40 && bus.o_ack !== v; i++) step();
        chk(tag, 32'(bus.o_ack), 32'(v));
    endtask

    task automatic hs(input logic [7:0] w);
        bus.i_data = w;
        bus.i_req  = 1'b1;
        wait_ack(1'b1, "hs_ack_rise");
        bus.i_req  = 1'b0;
        wait_ack(1'b0, "hs_ack_fall");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        #2;
        chk("rst_ack",   32'(bus.o_ack),   32'd0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_data",  32'(bus.o_data),  32'd0);
        chk("rst_count", 32'(bus.o_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single word with latency checks.
        bus.i_data = 8'hA5;
        bus.i_req  = 1'b1;
        step();
        chk("single_ack_e1", 32'(bus.o_ack), 32'd0);
        step();
        chk("single_ack_e2", 32'(bus.o_ack), 32'd0);
        step();
        chk("single_ack_e3",  32'(bus.o_ack),   32'd1);
        chk("single_valid",   32'(bus.o_valid), 32'd1);
        chk("single_data",    32'(bus.o_data),  32'hA5);
        chk("single_count",   32'(bus.o_count), 32'd1);
`ifdef HANDSHAKE_RX_STATS_EN
        chk("single_xfer", 32'(xfer_count), 32'd1);
`endif
        bus.i_req = 1'b0;
        step();
        step();
        chk("single_ack_hold", 32'(bus.o_ack), 32'd1);
        step();
        chk("single_ack_drop", 32'(bus.o_ack), 32'd0);
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        chk("single_pop_valid", 32'(bus.o_valid), 32'd0);
        chk("single_pop_data",  32'(bus.o_data),  32'd0);
        chk("single_pop_count", 32'(bus.o_count), 32'd0);

        // Burst fill with consumer stalled; fifth request is backpressured.
        for (int k = 1; k <= 4; k++) hs(8'(k));
        chk("burst_count4", 32'(bus.o_count), 32'd4);
        chk("burst_head01", 32'(bus.o_data),  32'h01);
        bus.i_data = 8'h05;
        bus.i_req  = 1'b1;
        repeat (8) step();
        chk("burst_ack_withheld", 32'(bus.o_ack),   32'd0);
        chk("burst_full_count",   32'(bus.o_count), 32'd4);
`ifdef HANDSHAKE_RX_STATS_EN
        chk("burst_stall_on", 32'(stall), 32'd1);
`endif
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        chk("burst_pop_count", 32'(bus.o_count), 32'd3);
        chk("burst_pop_head",  32'(bus.o_data),  32'h02);
        wait_ack(1'b1, "burst_fifth_ack");
        chk("burst_refill_count", 32'(bus.o_count), 32'd4);
`ifdef HANDSHAKE_RX_STATS_EN
        chk("burst_stall_off", 32'(stall), 32'd0);
`endif
        bus.i_req = 1'b0;
        wait_ack(1'b0, "burst_fifth_release");
        bus.i_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("burst_drain", 32'(bus.o_data), 32'(k));
            step();
        end
        bus.i_ready = 1'b0;
        chk("burst_empty", 32'(bus.o_count), 32'd0);

        // Pop and write on the same edge at occupancy 2.
        hs(8'h11);
        hs(8'h12);
        chk("pw_count_pre", 32'(bus.o_count), 32'd2);
        bus.i_data = 8'h13;
        bus.i_req  = 1'b1;
        step();
        step();
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        chk("pw_ack",   32'(bus.o_ack),   32'd1);
        chk("pw_count", 32'(bus.o_count), 32'd2);
        chk("pw_head",  32'(bus.o_data),  32'h12);
        bus.i_req = 1'b0;
        wait_ack(1'b0, "pw_release");
        bus.i_ready = 1'b1;
        chk("pw_drain12", 32'(bus.o_data), 32'h12);
        step();
        chk("pw_drain13", 32'(bus.o_data), 32'h13);
        step();
        bus.i_ready = 1'b0;
        chk("pw_empty", 32'(bus.o_count), 32'd0);

        // Pointer wrap with the consumer always ready.
        bus.i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.i_data = 8'(8'h20 + i);
            bus.i_req  = 1'b1;
            wait_ack(1'b1, "wrap_ack");
            chk("wrap_data", 32'(bus.o_data), 32'(8'h20 + i));
            bus.i_req = 1'b0;
            wait_ack(1'b0, "wrap_release");
        end
        bus.i_ready = 1'b0;
        chk("wrap_count", 32'(bus.o_count), 32'd0);
        chk("wrap_valid", 32'(bus.o_valid), 32'd0);

        // Reset in the middle of a handshake with the request held.
        bus.i_data = 8'h77;
        bus.i_req  = 1'b1;
        wait_ack(1'b1, "mid_ack");
        chk("mid_count_pre", 32'(bus.o_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack",   32'(bus.o_ack),   32'd0);
        chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.o_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rel_e1", 32'(bus.o_ack), 32'd0);
        step();
        chk("mid_rel_e2", 32'(bus.o_ack), 32'd0);
        step();
        chk("mid_rel_ack",   32'(bus.o_ack),   32'd1);
        chk("mid_rel_count", 32'(bus.o_count), 32'd1);
        chk("mid_rel_data",  32'(bus.o_data),  32'h77);
        repeat (5) step();
        chk("mid_no_rewrite", 32'(bus.o_count), 32'd1);
        bus.i_req = 1'b0;
        wait_ack(1'b0, "mid_release");
        hs(8'h31);
        hs(8'h32);
        chk("post_count3", 32'(bus.o_count), 32'd3);
`ifdef HANDSHAKE_RX_STATS_EN
        chk("stats_xfer3", 32'(xfer_count), 32'd3);
`endif
        bus.i_ready = 1'b1;
        chk("post_drain77", 32'(bus.o_data), 32'h77);
        step();
        chk("post_drain31", 32'(bus.o_data), 32'h31);
        step();
        chk("post_drain32", 32'(bus.o_data), 32'h32);
        step();
        bus.i_ready = 1'b0;
        chk("post_empty", 32'(bus.o_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
